// File: rtl/instr_encoder_if.sv
// Interface bundling the encode-request channel, the instruction-memory write
// channel, the start pulse and the error reporting of instr_encoder.
// master: the side that issues requests and owns the memory (e.g. a testbench).
// slave : the encoder itself.
interface instr_encoder_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        err;
  logic [7:0]  err_cnt;

  modport master (
    output start, in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data, wr_be, err, err_cnt
  );

  modport slave (
    input  start, in_valid, in_mnem, in_rd, in_rs1, in_rs2, in_imm, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data, wr_be, err, err_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: turns RV32I mnemonic + register/immediate fields into 32-bit
// instruction words and writes them to consecutive instruction-memory addresses
// starting at BASE_ADDR. One output register gives latency 1 and one word per
// cycle throughput. Illegal mnemonics are rejected with an err pulse and a
// saturating err_cnt.
// Optional build macro ENC_RANGE_CHECK_EN: when defined, immediates that do not
// fit their instruction format are rejected like illegal mnemonics; otherwise
// they are silently truncated to the bits the format holds.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);

  typedef enum logic [5:0] {
    M_LUI   = 6'd0,  M_AUIPC = 6'd1,  M_JAL   = 6'd2,  M_JALR  = 6'd3,
    M_BEQ   = 6'd4,  M_BNE   = 6'd5,  M_BLT   = 6'd6,  M_BGE   = 6'd7,
    M_BLTU  = 6'd8,  M_BGEU  = 6'd9,  M_LB    = 6'd10, M_LH    = 6'd11,
    M_LW    = 6'd12, M_LBU   = 6'd13, M_LHU   = 6'd14, M_SB    = 6'd15,
    M_SH    = 6'd16, M_SW    = 6'd17, M_ADDI  = 6'd18, M_SLTI  = 6'd19,
    M_SLTIU = 6'd20, M_XORI  = 6'd21, M_ORI   = 6'd22, M_ANDI  = 6'd23,
    M_SLLI  = 6'd24, M_SRLI  = 6'd25, M_SRAI  = 6'd26, M_ADD   = 6'd27,
    M_SUB   = 6'd28, M_SLL   = 6'd29, M_SLT   = 6'd30, M_SLTU  = 6'd31,
    M_XOR   = 6'd32, M_SRL   = 6'd33, M_SRA   = 6'd34, M_OR    = 6'd35,
    M_AND   = 6'd36
  } mnem_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] encWord;
  logic        immOk;
  logic        legal;
  logic        inReady;
  logic        accept;

  logic        readyEn_q, readyEn_d;
  logic        wrValid_q, wrValid_d;
  logic [31:0] wrData_q,  wrData_d;
  logic [31:0] addr_q,    addr_d;
  logic        err_q,     err_d;
  logic [7:0]  errCnt_q,  errCnt_d;

  // Map the mnemonic to its instruction format and major opcode
  always_comb begin
    fmt    = FMT_BAD;
    opcode = 7'b0000000;
    case (bus.in_mnem)
      M_LUI:   begin fmt = FMT_U; opcode = OP_LUI;   end
      M_AUIPC: begin fmt = FMT_U; opcode = OP_AUIPC; end
      M_JAL:   begin fmt = FMT_J; opcode = OP_JAL;   end
      M_JALR:  begin fmt = FMT_I; opcode = OP_JALR;  end
      M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU:
               begin fmt = FMT_B; opcode = OP_BRANCH; end
      M_LB, M_LH, M_LW, M_LBU, M_LHU:
               begin fmt = FMT_I; opcode = OP_LOAD;   end
      M_SB, M_SH, M_SW:
               begin fmt = FMT_S; opcode = OP_STORE;  end
      M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI:
               begin fmt = FMT_I; opcode = OP_IMM;    end
      M_SLLI, M_SRLI, M_SRAI:
               begin fmt = FMT_SH; opcode = OP_IMM;   end
      M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND:
               begin fmt = FMT_R; opcode = OP_REG;    end
      default: begin fmt = FMT_BAD; opcode = 7'b0000000; end
    endcase
  end

  // Minor opcode fields; funct7 0x20 only marks the subtract/arithmetic-shift variants
  always_comb begin
    funct3 = 3'd0;
    case (bus.in_mnem)
      M_BNE, M_LH, M_SH, M_SLLI, M_SLL:              funct3 = 3'd1;
      M_LW, M_SW, M_SLTI, M_SLT:                     funct3 = 3'd2;
      M_SLTIU, M_SLTU:                               funct3 = 3'd3;
      M_BLT, M_LBU, M_XORI, M_XOR:                   funct3 = 3'd4;
      M_BGE, M_LHU, M_SRLI, M_SRAI, M_SRL, M_SRA:    funct3 = 3'd5;
      M_BLTU, M_ORI, M_OR:                           funct3 = 3'd6;
      M_BGEU, M_ANDI, M_AND:                         funct3 = 3'd7;
      default:                                       funct3 = 3'd0;
    endcase
    funct7 = 7'h00;
    case (bus.in_mnem)
      M_SUB, M_SRA, M_SRAI: funct7 = 7'h20;
      default:              funct7 = 7'h00;
    endcase
  end

  // Scatter register and immediate fields into the bit layout of the format
  always_comb begin
    encWord = 32'd0;
    case (fmt)
      FMT_R:  encWord = {funct7, bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, opcode};
      FMT_I:  encWord = {bus.in_imm[11:0], bus.in_rs1, funct3, bus.in_rd, opcode};
      FMT_SH: encWord = {funct7, bus.in_imm[4:0], bus.in_rs1, funct3, bus.in_rd, opcode};
      FMT_S:  encWord = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, funct3,
                         bus.in_imm[4:0], opcode};
      FMT_B:  encWord = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, funct3,
                         bus.in_imm[4:1], bus.in_imm[11], opcode};
      FMT_U:  encWord = {bus.in_imm[31:12], bus.in_rd, opcode};
      FMT_J:  encWord = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                         bus.in_imm[19:12], bus.in_rd, opcode};
      default: encWord = 32'd0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] immS;
  assign immS = $signed(bus.in_imm);

  // Reject immediates the chosen format cannot represent exactly
  always_comb begin
    immOk = 1'b1;
    case (fmt)
      FMT_I, FMT_S: immOk = (immS >= -32'sd2048) && (immS <= 32'sd2047);
      FMT_B:        immOk = (immS >= -32'sd4096) && (immS <= 32'sd4094) && !bus.in_imm[0];
      FMT_J:        immOk = (immS >= -32'sd1048576) && (immS <= 32'sd1048574) && !bus.in_imm[0];
      FMT_U:        immOk = (bus.in_imm[11:0] == 12'd0);
      FMT_SH:       immOk = (immS >= 32'sd0) && (immS <= 32'sd31);
      default:      immOk = 1'b1;
    endcase
  end
`else
  assign immOk = 1'b1;
`endif

  assign legal   = (fmt != FMT_BAD) && immOk;
  assign inReady = readyEn_q && !bus.start && (!wrValid_q || bus.wr_ready);
  assign accept  = bus.in_valid && inReady;

  // Next-state: start wins over everything, otherwise retire the pending write and load a new one
  always_comb begin
    readyEn_d = 1'b1;
    wrValid_d = wrValid_q;
    wrData_d  = wrData_q;
    addr_d    = addr_q;
    err_d     = 1'b0;
    errCnt_d  = errCnt_q;
    if (bus.start) begin
      wrValid_d = 1'b0;
      addr_d    = BASE_ADDR;
      errCnt_d  = 8'd0;
    end else begin
      if (wrValid_q && bus.wr_ready) begin
        wrValid_d = 1'b0;
        addr_d    = addr_q + 32'd4;
      end
      if (accept) begin
        if (legal) begin
          wrValid_d = 1'b1;
          wrData_d  = encWord;
        end else begin
          err_d = 1'b1;
          if (errCnt_q != 8'hFF) begin
            errCnt_d = errCnt_q + 8'd1;
          end
        end
      end
    end
  end

  // State registers; reset drops the write and parks the address at BASE_ADDR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readyEn_q <= 1'b0;
      wrValid_q <= 1'b0;
      wrData_q  <= 32'd0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      errCnt_q  <= 8'd0;
    end else begin
      readyEn_q <= readyEn_d;
      wrValid_q <= wrValid_d;
      wrData_q  <= wrData_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign bus.in_ready = inReady;
  assign bus.wr_valid = wrValid_q;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = wrData_q;
  assign bus.wr_be    = wrValid_q ? 4'b1111 : 4'b0000;
  assign bus.err      = err_q;
  assign bus.err_cnt  = errCnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed encodings, stall, start, error and
// asynchronous reset scenarios followed by randomized traffic, all checked
// against a table-driven RV32I reference encoder and a write-queue scoreboard.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] expQ[$];
  logic [31:0] expAddr;
  logic [7:0]  expErrCnt;
  logic        expErr;
  logic        readyEn;

  string fmtStr = "UUJIBBBBBBIIIIISSSIIIIIIHHHRRRRRRRRRR";
  string f3Str  = "0000014567012450120234671550012345567";

  instr_encoder_if bus();

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic logic [31:0] refOpcode(int m);
    if (m == 0) return 32'h37;
    if (m == 1) return 32'h17;
    if (m == 2) return 32'h6F;
    if (m == 3) return 32'h67;
    if (m <= 9) return 32'h63;
    if (m <= 14) return 32'h03;
    if (m <= 17) return 32'h23;
    if (m <= 26) return 32'h13;
    return 32'h33;
  endfunction

  function automatic logic [31:0] refWord(int m, logic [4:0] rd, logic [4:0] rs1,
                                          logic [4:0] rs2, logic [31:0] imm);
    logic [31:0] op, f3, f7, r;
    byte         f;
    op = refOpcode(m);
    f3 = 32'(f3Str[m] - 8'd48);
    f7 = (m == 26 || m == 28 || m == 34) ? 32'h20 : 32'h0;
    f  = fmtStr[m];
    r  = 32'd0;
    case (f)
      "R": r = (f7 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | op;
      "I": r = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | op;
      "H": r = (f7 << 25) | ((imm & 32'h1F) << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | op;
      "S": r = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12)
               | ((imm & 32'h1F) << 7) | op;
      "B": r = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
               | (32'(rs1) << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
               | (((imm >> 11) & 32'h1) << 7) | op;
      "U": r = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | op;
      "J": r = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
               | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | op;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic bit refLegal(int m, logic [31:0] imm);
`ifdef ENC_RANGE_CHECK_EN
    int  s;
    byte f;
`endif
    if (m > 36) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    s = imm;
    f = fmtStr[m];
    case (f)
      "I", "S": return (s >= -2048) && (s <= 2047);
      "B":      return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      "J":      return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      "U":      return (imm % 4096) == 0;
      "H":      return (s >= 0) && (s <= 31);
      default:  return 1'b1;
    endcase
`else
    return imm == imm;
`endif
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic applyStimulus(bit st, bit v, int m, logic [4:0] rd, logic [4:0] rs1,
                               logic [4:0] rs2, logic [31:0] imm, bit rdy);
    bus.start    = st;
    bus.in_valid = v;
    bus.in_mnem  = 6'(m);
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    bus.wr_ready = rdy;
  endtask

  task automatic modelReset();
    expQ.delete();
    expAddr   = BASE;
    expErrCnt = 8'd0;
    expErr    = 1'b0;
    readyEn   = 1'b0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the scoreboard on the edge
  task automatic runCycle();
    bit expReady, accept;
    @(negedge clk);
    expReady = readyEn && rst_n && !bus.start && (expQ.size() == 0 || bus.wr_ready);
    checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
    checkOutput("wr_valid", 32'(bus.wr_valid), 32'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      checkOutput("wr_data", bus.wr_data, expQ[0]);
      checkOutput("wr_addr", bus.wr_addr, expAddr);
      checkOutput("wr_be", 32'(bus.wr_be), 32'hF);
    end else begin
      checkOutput("wr_be_idle", 32'(bus.wr_be), 32'h0);
    end
    if (!rst_n) checkOutput("wr_data_rst", bus.wr_data, 32'h0);
    checkOutput("err", 32'(bus.err), 32'(expErr));
    checkOutput("err_cnt", 32'(bus.err_cnt), 32'(expErrCnt));
    accept = bus.in_valid && expReady;
    @(posedge clk);
    if (!rst_n) begin
      modelReset();
    end else if (bus.start) begin
      expQ.delete();
      expAddr   = BASE;
      expErrCnt = 8'd0;
      expErr    = 1'b0;
      readyEn   = 1'b1;
    end else begin
      expErr = 1'b0;
      if (expQ.size() != 0 && bus.wr_ready) begin
        void'(expQ.pop_front());
        expAddr = expAddr + 32'd4;
      end
      if (accept) begin
        if (refLegal(int'(bus.in_mnem), bus.in_imm)) begin
          expQ.push_back(refWord(int'(bus.in_mnem), bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm));
        end else begin
          expErr = 1'b1;
          if (expErrCnt != 8'hFF) expErrCnt = expErrCnt + 8'd1;
        end
      end
      readyEn = 1'b1;
    end
    #1;
  endtask

  task automatic idle(bit rdy);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, rdy);
    runCycle();
  endtask

  initial begin
    logic [31:0] imm;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    runCycle();
    runCycle();
    rst_n = 1'b1;
    idle(1);

    // Reference encodings, written back to back
    applyStimulus(0, 1, 18, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    runCycle();
    checkOutput("addi_data", bus.wr_data, 32'h0050_0093);
    checkOutput("addi_addr", bus.wr_addr, BASE);
    applyStimulus(0, 1, 27, 5'd3, 5'd1, 5'd2, 32'd0, 1);
    runCycle();
    checkOutput("add_data", bus.wr_data, 32'h0020_81B3);
    checkOutput("add_addr", bus.wr_addr, BASE + 32'd4);
    applyStimulus(0, 1, 28, 5'd3, 5'd1, 5'd2, 32'd0, 1);
    runCycle();
    checkOutput("sub_data", bus.wr_data, 32'h4020_81B3);
    applyStimulus(0, 1, 4, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1);
    runCycle();
    checkOutput("beq_data", bus.wr_data, 32'hFE20_8EE3);
    applyStimulus(0, 1, 0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1);
    runCycle();
    checkOutput("lui_data", bus.wr_data, 32'h1234_52B7);
    checkOutput("lui_addr", bus.wr_addr, BASE + 32'd16);
    idle(1);

    // Back-pressure: one write pending, a second request waits three cycles
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    runCycle();
    applyStimulus(0, 1, 18, 5'd1, 5'd0, 5'd0, 32'd5, 0);
    runCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 27, 5'd3, 5'd1, 5'd2, 32'd0, 0);
      runCycle();
      checkOutput("stall_ready", 32'(bus.in_ready), 32'h0);
      checkOutput("stall_data", bus.wr_data, 32'h0050_0093);
      checkOutput("stall_addr", bus.wr_addr, BASE);
    end
    applyStimulus(0, 1, 27, 5'd3, 5'd1, 5'd2, 32'd0, 1);
    runCycle();
    checkOutput("queued_data", bus.wr_data, 32'h0020_81B3);
    checkOutput("queued_addr", bus.wr_addr, BASE + 32'd4);
    idle(1);

    // Out-of-range I immediate: rejected with the range check, truncated without it
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    runCycle();
    applyStimulus(0, 1, 18, 5'd1, 5'd0, 5'd0, 32'd2048, 1);
    runCycle();
`ifdef ENC_RANGE_CHECK_EN
    checkOutput("imm2048_err", 32'(bus.err), 32'h1);
    checkOutput("imm2048_cnt", 32'(bus.err_cnt), 32'h1);
    checkOutput("imm2048_nowr", 32'(bus.wr_valid), 32'h0);
`else
    checkOutput("imm2048_data", bus.wr_data, 32'h8000_0093);
`endif
    applyStimulus(0, 1, 18, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    runCycle();
`ifdef ENC_RANGE_CHECK_EN
    checkOutput("after_rej_addr", bus.wr_addr, BASE);
`else
    checkOutput("after_trunc_addr", bus.wr_addr, BASE + 32'd4);
`endif
    idle(1);

    // Illegal mnemonic, then start while a write is pending
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    runCycle();
    applyStimulus(0, 1, 40, 5'd1, 5'd2, 5'd3, 32'd0, 1);
    runCycle();
    checkOutput("mnem40_err", 32'(bus.err), 32'h1);
    checkOutput("mnem40_cnt", 32'(bus.err_cnt), 32'h1);
    applyStimulus(0, 1, 18, 5'd1, 5'd0, 5'd0, 32'd5, 0);
    runCycle();
    checkOutput("err_pulse_end", 32'(bus.err), 32'h0);
    applyStimulus(1, 1, 27, 5'd3, 5'd1, 5'd2, 32'd0, 0);
    runCycle();
    checkOutput("start_drop", 32'(bus.wr_valid), 32'h0);
    checkOutput("start_cnt", 32'(bus.err_cnt), 32'h0);
    applyStimulus(0, 1, 2, 5'd1, 5'd0, 5'd0, 32'd2048, 1);
    runCycle();
    checkOutput("start_addr", bus.wr_addr, BASE);
    idle(1);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      applyStimulus(0, 1, 37 + (i % 27), 5'd0, 5'd0, 5'd0, 32'd0, 1);
      runCycle();
    end
    idle(1);
    checkOutput("err_cnt_sat", 32'(bus.err_cnt), 32'hFF);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    runCycle();

    // Randomized traffic against the reference model
    for (int i = 0; i < 700; i++) begin
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 80)) - 32'd40;
        2:       imm = 32'($urandom_range(0, 10000)) - 32'd5000;
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 39)), 5'($urandom), 5'($urandom), 5'($urandom),
                    imm, $urandom_range(0, 2) != 0);
      runCycle();
    end
    idle(1);
    idle(1);

    // Asynchronous reset in the middle of a stall
    applyStimulus(0, 1, 18, 5'd1, 5'd0, 5'd0, 32'd5, 0);
    runCycle();
    checkOutput("pre_rst_valid", 32'(bus.wr_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(bus.wr_valid), 32'h0);
    checkOutput("async_be", 32'(bus.wr_be), 32'h0);
    checkOutput("async_ready", 32'(bus.in_ready), 32'h0);
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    rst_n = 1'b1;
    applyStimulus(0, 1, 18, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    runCycle();
    applyStimulus(0, 1, 18, 5'd1, 5'd0, 5'd0, 32'd5, 1);
    runCycle();
    checkOutput("post_rst_addr", bus.wr_addr, BASE);
    idle(1);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: first instruction-memory byte address written after reset or start.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse beginning a new program image.
REQ-005 SHALL have port in_valid  input  1  encode request valid.
REQ-006 SHALL have port in_ready  output  1  encoder accepts request this cycle.
REQ-007 SHALL have port in_mnem  input  6  mnemonic code, 0..36 in order: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-008 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register fields; fields unused by the format are ignored.
REQ-009 SHALL have port in_imm  input  32  signed immediate as byte value/offset; U-type carries the full 32-bit value; shifts carry shamt.
REQ-010 SHALL have port wr_valid  output  1  instruction-memory write request pending.
REQ-011 SHALL have port wr_ready  input  1  memory accepts write this cycle.
REQ-012 SHALL have ports wr_addr  output  32, wr_data  output  32, wr_be  output  4 (4'b1111 whenever wr_valid=1, else 4'b0000).
REQ-013 SHALL have port err  output  1  one-cycle pulse: request rejected.
REQ-014 SHALL have port err_cnt  output  8  saturating count of rejected requests.

Function
REQ-015 SHALL register one encoded word: request accepted on edge N (in_valid & in_ready) appears on wr_valid/wr_data after edge N, i.e. latency 1.
REQ-016 SHALL drive in_ready = !start & (!wr_valid | wr_ready), allowing back-to-back throughput of one word per cycle.
REQ-017 SHALL hold wr_valid, wr_addr, wr_data stable while wr_valid=1 and wr_ready=0.
REQ-018 SHALL encode standard RV32I formats: R (funct7 0x20 for SUB/SRA, else 0), I, I-shift (imm[31:25]=0x20 for SRAI), S, B, U, J, with standard opcodes and funct3.
REQ-019 SHALL increment the address counter by 4 on each completed write (wr_valid & wr_ready); wraps modulo 2^32.
REQ-020 SHALL reject in_mnem >= 37: no write, err pulse on the cycle after acceptance, err_cnt+1.
REQ-021 SHALL saturate err_cnt at 8'hFF.
REQ-022 SHALL, on start, reset address counter to BASE_ADDR, clear err_cnt, and drop any pending write (wr_valid=0 after that edge); start overrides simultaneous handshakes.

Reset
REQ-023 SHALL, while rst_n=0, force wr_valid=0, wr_data=0, wr_be=0, err=0, err_cnt=0, address counter=BASE_ADDR, in_ready=0; in_ready follows REQ-016 from the first edge after release.

Configuration
REQ-024 SHALL honour macro ENC_RANGE_CHECK_EN: when defined, reject (as REQ-020) I/S imm outside [-2048,2047], B imm outside [-4096,4094] or odd, J imm outside [-1048576,1048574] or odd, U imm with imm[11:0]!=0, shift imm outside [0,31].
REQ-025 SHALL, when ENC_RANGE_CHECK_EN is undefined, perform no range check: fields silently truncated to their bit slices; illegal-mnemonic rejection remains.

Verification
REQ-026 SHALL cover: ADDI rd=1 rs1=0 imm=5 -> wr_data 0x00500093 at wr_addr BASE_ADDR one cycle later; ADD rd=3 rs1=1 rs2=2 -> 0x002081B3; SUB same -> 0x402081B3.
REQ-027 SHALL cover: BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; LUI rd=5 imm=0x12345000 -> 0x123452B7.
REQ-028 SHALL cover: wr_ready held 0 for 3 cycles with two queued requests -> in_ready=0, wr_data stable, addresses BASE_ADDR then BASE_ADDR+4.
REQ-029 SHALL cover: ADDI imm=2048 with ENC_RANGE_CHECK_EN -> no write, err pulse, err_cnt=1, next write still at current address; without macro -> wr_data 0x80000093 (rd=1, rs1=0).
REQ-030 SHALL cover: in_mnem=40 -> err pulse, err_cnt=1; start with write pending -> wr_valid=0 next cycle, err_cnt=0, next write at BASE_ADDR.
REQ-031 SHALL cover: rst_n asserted mid-stall -> wr_valid=0 immediately (asynchronously), counter=BASE_ADDR after release.
